// File: rtl/arm_microsequencer.sv
// Microprogrammed control unit for the multicycle ARM-subset processor.
// One microstate per cycle. The registered control word is built for the state being entered.
module arm_microsequencer #(
  parameter int SW = 35,
  parameter int NS = 6
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [31:0]   IR_OUT,
  input  logic          MOC,
  input  logic          COND,
  input  logic          LSM_DETECT,
  input  logic          LSM_END,
  output logic [SW-1:0] cu_datapath
);

  localparam logic [NS-1:0] S_START   = NS'(0);
  localparam logic [NS-1:0] S_FETCH   = NS'(1);
  localparam logic [NS-1:0] S_PCINC   = NS'(2);
  localparam logic [NS-1:0] S_IRWAIT  = NS'(3);
  localparam logic [NS-1:0] S_IRLOAD  = NS'(4);
  localparam logic [NS-1:0] S_DECODE  = NS'(5);
  localparam logic [NS-1:0] S_DP_IMM  = NS'(10);
  localparam logic [NS-1:0] S_DP_REG  = NS'(11);
  localparam logic [NS-1:0] S_LD_ADDR = NS'(20);
  localparam logic [NS-1:0] S_LD_WAIT = NS'(21);
  localparam logic [NS-1:0] S_LD_WB   = NS'(22);
  localparam logic [NS-1:0] S_ST_ADDR = NS'(24);
  localparam logic [NS-1:0] S_ST_DATA = NS'(25);
  localparam logic [NS-1:0] S_ST_WAIT = NS'(26);
  localparam logic [NS-1:0] S_BL_LINK = NS'(30);
  localparam logic [NS-1:0] S_BR_JUMP = NS'(31);
  localparam logic [NS-1:0] S_LSM_BASE = NS'(40);
  localparam logic [NS-1:0] S_LSM_TEST = NS'(41);
  localparam logic [NS-1:0] S_LSM_XFER = NS'(42);
  localparam logic [NS-1:0] S_LSM_NEXT = NS'(43);

  localparam int B_RFLD = 34, B_IRLD = 33, B_MARLD = 32, B_MDRLD = 31, B_FRLD = 30;
  localparam int B_MOV = 29, B_RW = 28;
  localparam int B_MD = 14, B_ME = 13, B_MF = 12, B_MG = 11, B_MH = 10, B_MI = 9;

  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [2:0] MS_BYTE = 3'b000;
  localparam logic [2:0] MS_WORD = 3'b010;
  localparam logic [1:0] SEL_0 = 2'b00, SEL_1 = 2'b01, SEL_2 = 2'b10, SEL_3 = 2'b11;

  logic [NS-1:0] state;
  logic [NS-1:0] next_state;
  logic          unused_ir;

  // Only the opcode-class and addressing bits of the instruction steer the sequencer.
  assign unused_ir = ^{IR_OUT[31:28], IR_OUT[19:0]};

  function automatic logic [SW-1:0] rom(input logic [NS-1:0] s, input logic [31:0] ir);
    logic [SW-1:0] w;
    w = '0;
    case (s)
      S_FETCH: begin
        w[B_MARLD] = 1'b1; w[20:19] = SEL_2; w[B_MF] = 1'b1;
      end
      S_PCINC: begin
        w[B_RFLD] = 1'b1; w[20:19] = SEL_2; w[18:17] = SEL_2; w[24:21] = ALU_ADD;
        w[16:15] = SEL_1; w[B_MOV] = 1'b1; w[B_RW] = 1'b1; w[27:25] = MS_WORD;
      end
      S_IRWAIT: begin
        w[B_MOV] = 1'b1; w[B_RW] = 1'b1; w[27:25] = MS_WORD; w[B_MDRLD] = 1'b1;
      end
      S_IRLOAD: w[B_IRLD] = 1'b1;
      S_DP_IMM, S_DP_REG: begin
        // TST/TEQ/CMP/CMN only update flags.
        w[B_RFLD] = (ir[24:23] != 2'b10);
        w[B_FRLD] = ir[20];
        w[B_MH]   = 1'b1;
        w[B_MI]   = (s == S_DP_REG);
      end
      S_LD_ADDR, S_ST_ADDR: begin
        w[B_MARLD] = 1'b1; w[24:21] = ir[23] ? ALU_ADD : ALU_SUB; w[B_MI] = ir[25];
      end
      S_LD_WAIT: begin
        w[B_MOV] = 1'b1; w[B_RW] = 1'b1; w[B_MDRLD] = 1'b1;
        w[27:25] = ir[22] ? MS_BYTE : MS_WORD;
      end
      S_LD_WB: begin
        w[B_RFLD] = 1'b1; w[B_MG] = 1'b1;
      end
      S_ST_DATA: begin
        w[B_MDRLD] = 1'b1; w[B_ME] = 1'b1; w[20:19] = SEL_1;
      end
      S_ST_WAIT: begin
        w[B_MOV] = 1'b1; w[27:25] = ir[22] ? MS_BYTE : MS_WORD;
      end
      S_BL_LINK: begin
        w[B_RFLD] = 1'b1; w[20:19] = SEL_2; w[18:17] = SEL_2; w[24:21] = ALU_SUB;
        w[16:15] = SEL_2;
      end
      S_BR_JUMP: begin
        w[B_RFLD] = 1'b1; w[20:19] = SEL_2; w[18:17] = SEL_3; w[24:21] = ALU_ADD;
        w[16:15] = SEL_1;
      end
      S_LSM_BASE: begin
        w[B_MARLD] = 1'b1; w[B_MF] = 1'b1;
      end
      S_LSM_XFER: begin
        w[B_MOV] = 1'b1; w[B_RW] = ir[20]; w[27:25] = MS_WORD;
        if (ir[20]) begin
          w[B_MDRLD] = 1'b1; w[B_RFLD] = 1'b1; w[B_MG] = 1'b1; w[16:15] = SEL_3;
        end else begin
          w[20:19] = SEL_3; w[B_ME] = 1'b1;
        end
      end
      S_LSM_NEXT: begin
        w[B_MARLD] = 1'b1; w[B_MD] = 1'b1; w[18:17] = SEL_2; w[24:21] = ALU_ADD;
      end
      default: w = '0;
    endcase
    return w;
  endfunction

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_START:    next_state = S_FETCH;
      S_FETCH:    next_state = S_PCINC;
      S_PCINC:    next_state = S_IRWAIT;
      S_IRWAIT:   next_state = MOC ? S_IRLOAD : S_IRWAIT;
      S_IRLOAD:   next_state = S_DECODE;
      S_DECODE: begin
        if (!COND)                        next_state = S_FETCH;
        else if (IR_OUT[27:26] == 2'b00)  next_state = IR_OUT[25] ? S_DP_IMM : S_DP_REG;
        else if (IR_OUT[27:26] == 2'b01)  next_state = IR_OUT[20] ? S_LD_ADDR : S_ST_ADDR;
        else if (IR_OUT[27:25] == 3'b100) next_state = S_LSM_BASE;
        else if (IR_OUT[27:25] == 3'b101) next_state = IR_OUT[24] ? S_BL_LINK : S_BR_JUMP;
        else                              next_state = S_FETCH;
      end
      S_LD_ADDR:  next_state = S_LD_WAIT;
      S_LD_WAIT:  next_state = MOC ? S_LD_WB : S_LD_WAIT;
      S_ST_ADDR:  next_state = S_ST_DATA;
      S_ST_DATA:  next_state = S_ST_WAIT;
      S_ST_WAIT:  next_state = MOC ? S_FETCH : S_ST_WAIT;
      S_BL_LINK:  next_state = S_BR_JUMP;
      S_LSM_BASE: next_state = S_LSM_TEST;
      S_LSM_TEST: next_state = LSM_DETECT ? S_LSM_XFER : S_LSM_NEXT;
      S_LSM_XFER: next_state = MOC ? S_LSM_NEXT : S_LSM_XFER;
      S_LSM_NEXT: next_state = LSM_END ? S_FETCH : S_LSM_TEST;
      default:    next_state = S_FETCH;
    endcase
  end

  // State and control word register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= S_START;
      cu_datapath <= '0;
    end else begin
      state       <= next_state;
      cu_datapath <= rom(next_state, IR_OUT);
    end
  end

endmodule

// File: tb/tb_arm_microsequencer.sv
// Bench for arm_microsequencer: directed walk through each instruction class, then random traffic.
module tb_arm_microsequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ir;
  logic        moc, cond, lsm_detect, lsm_end;
  logic [34:0] cu_datapath;

  arm_microsequencer #(.SW(35), .NS(6)) dut (
    .CLK(clk), .RESET(rst), .IR_OUT(ir), .MOC(moc), .COND(cond),
    .LSM_DETECT(lsm_detect), .LSM_END(lsm_end), .cu_datapath(cu_datapath)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rfld, irld, marld, mdrld, frld, mov, rw;
    logic [2:0] ms;
    logic [3:0] alu;
    logic [1:0] ma, mb, mc;
    logic       md, me, mf, mg, mh, mi;
    logic [8:0] zero;
  } word_t;

  int    vectors = 0;
  int    miscompares = 0;
  bit    chk = 1'b0;
  int    ms = 0;
  word_t mw = '0;

  function automatic word_t model_word(input int s, input logic [31:0] i);
    word_t f;
    f = '0;
    case (s)
      1:  begin f.marld = 1; f.ma = 2; f.mf = 1; end
      2:  begin f.rfld = 1; f.ma = 2; f.mb = 2; f.alu = 4'd4; f.mc = 1; f.mov = 1; f.rw = 1; f.ms = 2; end
      3:  begin f.mov = 1; f.rw = 1; f.ms = 2; f.mdrld = 1; end
      4:  f.irld = 1;
      10, 11: begin
        f.rfld = !(i[24] && !i[23]); f.frld = i[20]; f.mh = 1; f.mi = (s == 11);
      end
      20, 24: begin f.marld = 1; f.alu = i[23] ? 4'd4 : 4'd2; f.mi = i[25]; end
      21: begin f.mov = 1; f.rw = 1; f.mdrld = 1; f.ms = i[22] ? 3'd0 : 3'd2; end
      22: begin f.rfld = 1; f.mg = 1; end
      25: begin f.mdrld = 1; f.me = 1; f.ma = 1; end
      26: begin f.mov = 1; f.ms = i[22] ? 3'd0 : 3'd2; end
      30: begin f.rfld = 1; f.ma = 2; f.mb = 2; f.alu = 4'd2; f.mc = 2; end
      31: begin f.rfld = 1; f.ma = 2; f.mb = 3; f.alu = 4'd4; f.mc = 1; end
      40: begin f.marld = 1; f.mf = 1; end
      42: begin
        f.mov = 1; f.rw = i[20]; f.ms = 2;
        if (i[20]) begin f.mdrld = 1; f.rfld = 1; f.mg = 1; f.mc = 3; end
        else begin f.ma = 3; f.me = 1; end
      end
      43: begin f.marld = 1; f.md = 1; f.mb = 2; f.alu = 4'd4; end
      default: f = '0;
    endcase
    return f;
  endfunction

  function automatic int model_next(input int s, input logic [31:0] i, input logic m, c, d, e);
    int n;
    n = 1;
    if (s == 0 || s == 1 || s == 2 || s == 4 || s == 20 || s == 24 || s == 25 || s == 30 || s == 40)
      n = s + 1;
    else if (s == 3)  n = m ? 4 : 3;
    else if (s == 21) n = m ? 22 : 21;
    else if (s == 26) n = m ? 1 : 26;
    else if (s == 42) n = m ? 43 : 42;
    else if (s == 41) n = d ? 42 : 43;
    else if (s == 43) n = e ? 1 : 41;
    else if (s == 5) begin
      if (!c)                     n = 1;
      else if (i[27:26] == 2'd0)  n = i[25] ? 10 : 11;
      else if (i[27:26] == 2'd1)  n = i[20] ? 20 : 24;
      else if (i[27:25] == 3'd4)  n = 40;
      else if (i[27:25] == 3'd5)  n = i[24] ? 30 : 31;
      else                        n = 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ms = 0; mw = '0;
    end else begin
      ms = model_next(ms, ir, moc, cond, lsm_detect, lsm_end);
      mw = model_word(ms, ir);
    end
  end

  always @(negedge clk) begin
    if (chk) begin
      vectors++;
      if (cu_datapath !== mw) begin
        miscompares++;
        $display("FAIL model_cmp t=%0t state=%0d got=%h want=%h", $time, ms, cu_datapath, mw);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [34:0] exp);
    vectors++;
    if (cu_datapath !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", name, cu_datapath, exp);
    end
  endtask

  // Walks from state 1 through the fetch to state 5 with the given instruction.
  task automatic fetch_to_decode(input logic [31:0] i, input logic c);
    moc = 0; cyc(); cyc();
    moc = 1; cyc();
    moc = 0; ir = i; cond = c; cyc();
  endtask

  localparam logic [34:0] W_FETCH = 35'h1_0010_1000;

  initial begin
    int passes;
    rst = 1; ir = '0; moc = 0; cond = 1; lsm_detect = 0; lsm_end = 0;
    cyc(); cyc();
    chk = 1'b1;
    lit("reset_word", 35'h0);

    rst = 0; cyc();  lit("fetch_s1", W_FETCH);
    cyc();           lit("fetch_s2", 35'h4_3494_8000);
    cyc();           lit("fetch_s3", 35'h0_B400_0000);
    for (int k = 0; k < 5; k++) begin
      cyc(); lit("moc_wait_s3", 35'h0_B400_0000);
    end
    moc = 1; cyc();  lit("irload_s4", 35'h2_0000_0000);
    moc = 0; ir = 32'hE281_1005; cond = 1;
    cyc();           lit("decode_s5", 35'h0);
    cyc();           lit("add_imm_s10", 35'h4_0000_0400);
    cyc();           lit("back_to_s1", W_FETCH);

    fetch_to_decode(32'hE153_0004, 1'b1);
    cyc();           lit("cmp_s11", 35'h0_4000_0600);
    cyc();
    fetch_to_decode(32'hE153_0004, 1'b0);
    cyc();           lit("cond_fail_s1", W_FETCH);

    fetch_to_decode(32'hE5D1_2004, 1'b1);
    cyc();           lit("ldrb_s20", 35'h1_0080_0000);
    cyc();           lit("ldrb_s21", 35'h0_B000_0000);
    cyc();           lit("ldrb_s21_hold", 35'h0_B000_0000);
    moc = 1; cyc();  lit("ldrb_s22", 35'h4_0000_0800);
    moc = 0; cyc();  lit("ldrb_done_s1", W_FETCH);

    fetch_to_decode(32'hEB00_0002, 1'b1);
    cyc();           lit("bl_s30", 35'h4_0055_0000);
    cyc();           lit("bl_s31", 35'h4_0096_8000);
    cyc();           lit("bl_done_s1", W_FETCH);

    fetch_to_decode(32'hE8BD_000F, 1'b1);
    cyc();           lit("ldm_s40", 35'h1_0000_1000);
    passes = 0;
    for (int k = 0; k < 80 && ms != 1; k++) begin
      if (ms == 41) lsm_detect = ~lsm_detect;
      if (ms == 43) passes++;
      lsm_end = (ms == 43) && (passes == 3);
      moc = k[0];
      cyc();
    end
    lsm_end = 0; lsm_detect = 0; moc = 0;
    lit("ldm_done_s1", W_FETCH);
    vectors++;
    if (passes != 3) begin
      miscompares++;
      $display("FAIL ldm_passes got=%0d want=3", passes);
    end

    fetch_to_decode(32'hE5D1_2004, 1'b1);
    cyc(); cyc();    lit("reset_pre_s21", 35'h0_B000_0000);
    rst = 1; cyc();  lit("reset_mid_s21", 35'h0);
    rst = 0; cyc();  lit("reset_recover_s1", W_FETCH);

    for (int k = 0; k < 3000; k++) begin
      rst        = ($urandom_range(0, 99) == 0);
      moc        = ($urandom_range(0, 2) == 0);
      cond       = ($urandom_range(0, 3) != 0);
      lsm_detect = $urandom_range(0, 1) == 1;
      lsm_end    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) ir = $urandom;
      cyc();
    end

    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
